// File: rtl/base_rd_arb_pkg.sv
// ============================================================================
// Module  : base_rd_arb_pkg
// Purpose : Shared types and helpers for the base_rd_arb read arbiter.
//           - state_t     : response-slot state (EMPTY / FULL)
//           - rr_pick     : round-robin one-hot pick starting at a pointer
//           - onehot2idx  : one-hot vector to binary index
// Ports   : none (package)
// Config  : BASE_RD_ARB_LOCK_EN is consumed by the interface and top, not here.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package base_rd_arb_pkg;

  // Helpers work on a fixed-width vector; arbiters up to this many ways.
  localparam int MAX_WAYS = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // First set bit of req in the circular order ptr, ptr+1, ..., n-1, 0, ...
  // Only the low n bits take part. ptr must be below n.
  function automatic logic [MAX_WAYS-1:0] rr_pick(input logic [MAX_WAYS-1:0] req,
                                                  input logic [3:0]          ptr,
                                                  input int                  n);
    logic [MAX_WAYS-1:0] g;
    logic                found;
    logic [4:0]          pos;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_WAYS; k++) begin
      if ((k < n) && !found) begin
        pos = {1'b0, ptr} + 5'(k);
        if (pos >= 5'(n)) pos = pos - 5'(n);
        if (req[pos[3:0]]) begin
          g[pos[3:0]] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return g;
  endfunction

  function automatic logic [3:0] onehot2idx(input logic [MAX_WAYS-1:0] oh);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < MAX_WAYS; k++) begin
      if (oh[k]) r = r | 4'(k);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/base_rd_arb_if.sv
// ============================================================================
// Module  : base_rd_arb_if
// Purpose : Bundle of requester, SRAM read-port and response-stream signals.
// Ports   : i_v/i_a/i_r   requester valid, address, ready (requester n at bit n,
//                         address bits [n*aw : n*aw+aw-1])
//           sram_re/ra/rd SRAM read enable, address, data (data one cycle later)
//           o_v/o_d/o_id/o_r  response valid, data, owner index, ready
//           i_lock        burst lock (only with BASE_RD_ARB_LOCK_EN)
// Modports: master = arbiter side, slave = requesters + SRAM + consumer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface base_rd_arb_if #(
  parameter int ways = 4,
  parameter int aw   = 8,
  parameter int dw   = 32
);
  localparam int iw = $clog2(ways);

  logic [0:ways-1]    i_v;
  logic [0:ways*aw-1] i_a;
  logic [0:ways-1]    i_r;
  logic               sram_re;
  logic [0:aw-1]      sram_ra;
  logic [0:dw-1]      sram_rd;
  logic               o_v;
  logic [0:dw-1]      o_d;
  logic [0:iw-1]      o_id;
  logic               o_r;
`ifdef BASE_RD_ARB_LOCK_EN
  logic [0:ways-1]    i_lock;
`endif

  modport master (
    input  i_v, i_a, sram_rd, o_r,
`ifdef BASE_RD_ARB_LOCK_EN
    input  i_lock,
`endif
    output i_r, sram_re, sram_ra, o_v, o_d, o_id
  );

  modport slave (
    output i_v, i_a, sram_rd, o_r,
`ifdef BASE_RD_ARB_LOCK_EN
    output i_lock,
`endif
    input  i_r, sram_re, sram_ra, o_v, o_d, o_id
  );

endinterface

`default_nettype wire

// File: rtl/base_rd_arb_rr.sv
// ============================================================================
// Module  : base_rr_arb
// Purpose : Combinational round-robin arbiter: request vector + pointer ->
//           one-hot grant, binary index of the winner and an any-grant flag.
//           Reusable by other arbiters (2..16 ways).
// Ports   : req   [ways-1:0] in   request vector
//           ptr   [iw-1:0]   in   highest-priority requester this cycle
//           grant [ways-1:0] out  one-hot or zero
//           idx   [iw-1:0]   out  winner index (0 when no grant)
//           any              out  some requester won
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module base_rr_arb
  import base_rd_arb_pkg::*;
#(
  parameter int ways = 4,
  parameter int iw   = $clog2(ways)
) (
  input  logic [ways-1:0] req,
  input  logic [iw-1:0]   ptr,
  output logic [ways-1:0] grant,
  output logic [iw-1:0]   idx,
  output logic            any
);

  logic [MAX_WAYS-1:0] w_req_x;
  logic [MAX_WAYS-1:0] w_gnt_x;
  logic                w_unused;

  assign w_req_x = MAX_WAYS'(req);
  assign w_gnt_x = rr_pick(w_req_x, 4'(ptr), ways);

  assign grant = w_gnt_x[ways-1:0];
  assign idx   = iw'(onehot2idx(w_gnt_x));
  assign any   = |w_gnt_x;

  // Upper bits of the widened grant are always zero for narrow arbiters.
  assign w_unused = ^w_gnt_x;

endmodule

`default_nettype wire

// File: rtl/base_rd_arb.sv
// ============================================================================
// Module  : base_rd_arb
// Purpose : Round-robin read arbiter sharing one SRAM read port among `ways`
//           valid/ready requesters. One read per cycle; read data returns on
//           a single valid/ready stream tagged with the winner's index. The
//           SRAM output register is the response holding latch, so reads are
//           suppressed while a response is stalled.
// Ports   : clk    in  clock, rising edge
//           reset  in  synchronous, active-low reset
//           bus    base_rd_arb_if.master (requesters, SRAM port, response)
// Config  : BASE_RD_ARB_LOCK_EN adds i_lock burst locking.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module base_rd_arb
  import base_rd_arb_pkg::*;
#(
  parameter int ways = 4,
  parameter int aw   = 8,
  parameter int dw   = 32
) (
  input  logic           clk,
  input  logic           reset,
  base_rd_arb_if.master  bus
);

  localparam int iw = $clog2(ways);

  state_t             r_state, w_state_nxt;
  logic [iw-1:0]      r_ptr, w_ptr_nxt;
  logic [iw-1:0]      r_oid;
  logic [ways-1:0]    w_v, w_req, w_gnt;
  logic [aw-1:0]      w_addr [ways];
  logic [iw-1:0]      w_idx, w_ptr_inc;
  logic               w_any, w_en, w_xfer;
  logic [dw-1:0]      w_rd;

  // New work is accepted only when the response slot is free or draining.
  assign w_en   = bus.o_r | (r_state == ST_EMPTY);
  // The winner always has i_v set, so a grant with enable is a transfer.
  assign w_xfer = w_any & w_en;

  generate
    for (genvar n = 0; n < ways; n++) begin : g_req
      assign w_v[n]     = bus.i_v[n];
      assign w_addr[n]  = bus.i_a[n*aw +: aw];
      assign bus.i_r[n] = w_gnt[n] & w_en;
    end
  endgenerate

`ifdef BASE_RD_ARB_LOCK_EN
  logic          r_locked, w_locked_nxt;
  logic [iw-1:0] r_lock_id, w_lock_id_nxt;
  logic          w_lk;

  // While a burst is locked only the lock owner may compete.
  assign w_req = r_locked ? (w_v & (ways'(1) << r_lock_id)) : w_v;
  assign w_lk  = bus.i_lock[w_idx];
`else
  assign w_req = w_v;
`endif

  base_rr_arb #(
    .ways (ways),
    .iw   (iw)
  ) u_rr (
    .req   (w_req),
    .ptr   (r_ptr),
    .grant (w_gnt),
    .idx   (w_idx),
    .any   (w_any)
  );

  // Explicit wrap so non-power-of-two arbiters never see an index >= ways.
  assign w_ptr_inc = (w_idx == iw'(ways - 1)) ? '0 : (w_idx + iw'(1));

  assign bus.sram_re = w_xfer;
  assign bus.sram_ra = w_any ? w_addr[w_idx] : '0;
  assign w_rd        = bus.sram_rd;
  assign bus.o_d     = w_rd;
  assign bus.o_v     = (r_state == ST_FULL);
  assign bus.o_id    = r_oid;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
`ifdef BASE_RD_ARB_LOCK_EN
    w_locked_nxt  = r_locked;
    w_lock_id_nxt = r_lock_id;
`endif
    if (w_xfer) begin
      w_state_nxt = ST_FULL;
    end else if (bus.o_r) begin
      w_state_nxt = ST_EMPTY;
    end

    if (w_xfer) begin
`ifdef BASE_RD_ARB_LOCK_EN
      if (w_lk) begin
        // Locked beats keep the pointer so the burst owner stays first.
        w_locked_nxt  = 1'b1;
        w_lock_id_nxt = w_idx;
      end else begin
        w_locked_nxt = 1'b0;
        w_ptr_nxt    = w_ptr_inc;
      end
`else
      w_ptr_nxt = w_ptr_inc;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
      r_ptr   <= '0;
      r_oid   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_xfer) r_oid <= w_idx;
    end
  end

`ifdef BASE_RD_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_locked  <= 1'b0;
      r_lock_id <= '0;
    end else begin
      r_locked  <= w_locked_nxt;
      r_lock_id <= w_lock_id_nxt;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_base_rd_arb.sv
// ============================================================================
// Module  : tb_base_rd_arb
// Purpose : Directed self-checking bench for base_rd_arb: a 4-way instance
//           (single request, fairness, backpressure, address change, reset
//           mid-stream) and a 3-way instance (pointer wrap). SRAM behaviour is
//           modelled with a fixed data pattern per address.
// Config  : drives i_lock to 0 when BASE_RD_ARB_LOCK_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_base_rd_arb;

  logic clk = 1'b0;
  logic reset;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  base_rd_arb_if #(.ways(4), .aw(8), .dw(32)) b4 ();
  base_rd_arb_if #(.ways(3), .aw(8), .dw(32)) b3 ();

  base_rd_arb #(.ways(4), .aw(8), .dw(32)) u_dut4 (.clk(clk), .reset(reset), .bus(b4));
  base_rd_arb #(.ways(3), .aw(8), .dw(32)) u_dut3 (.clk(clk), .reset(reset), .bus(b3));

  function automatic logic [31:0] mdat(input logic [7:0] a);
    return {8'hD0, a, ~a, 8'h5A};
  endfunction

  function automatic logic [0:3] oh4(input int n);
    logic [0:3] r;
    r = '0;
    r[n[1:0]] = 1'b1;
    return r;
  endfunction

  function automatic logic [0:2] oh3(input int n);
    logic [0:2] r;
    r = '0;
    r[n[1:0]] = 1'b1;
    return r;
  endfunction

  // SRAM models: registered read data, held while sram_re is low.
  always @(posedge clk) if (b4.sram_re) b4.sram_rd <= mdat(b4.sram_ra);
  always @(posedge clk) if (b3.sram_re) b3.sram_rd <= mdat(b3.sram_ra);

`ifdef BASE_RD_ARB_LOCK_EN
  initial begin
    b4.i_lock = '0;
    b3.i_lock = '0;
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fair [6] = '{3, 0, 1, 2, 3, 0};

    reset = 1'b0;
    b4.i_v = '0; b4.i_a = '0; b4.o_r = 1'b0;
    b3.i_v = '0; b3.i_a = '0; b3.o_r = 1'b0;
    repeat (3) tick();

    // Reset state
    #1;
    chk("rst_o_v",     32'(b4.o_v), 32'd0);
    chk("rst_o_id",    32'(b4.o_id), 32'd0);
    chk("rst_sram_re", 32'(b4.sram_re), 32'd0);
    chk("rst_i_r",     32'(b4.i_r), 32'd0);
    reset = 1'b1;
    tick();

    // Single request from requester 2, address 0x12
    b4.i_v[2] = 1'b1;
    b4.i_a[16 +: 8] = 8'h12;
    b4.o_r = 1'b1;
    #1;
    chk("single_i_r",     32'(b4.i_r), 32'(oh4(2)));
    chk("single_sram_re", 32'(b4.sram_re), 32'd1);
    chk("single_sram_ra", 32'(b4.sram_ra), 32'h12);
    tick();
    b4.i_v = '0;
    #1;
    chk("single_o_v",  32'(b4.o_v), 32'd1);
    chk("single_o_id", 32'(b4.o_id), 32'd2);
    chk("single_o_d",  32'(b4.o_d), mdat(8'h12));
    chk("idle_re",     32'(b4.sram_re), 32'd0);
    tick();
    chk("drain_o_v", 32'(b4.o_v), 32'd0);

    // Fairness: pointer sits at 3 after the single request
    for (int n = 0; n < 4; n++) b4.i_a[n*8 +: 8] = 8'h40 + 8'(n);
    b4.i_v = '1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fair_i_r", 32'(b4.i_r), 32'(oh4(fair[k])));
      chk("fair_ra",  32'(b4.sram_ra), 32'(8'h40 + 8'(fair[k])));
      if (k > 0) begin
        chk("fair_o_id", 32'(b4.o_id), 32'(fair[k-1]));
        chk("fair_o_d",  32'(b4.o_d), mdat(8'h40 + 8'(fair[k-1])));
      end
      tick();
    end

    // Backpressure: response (id 0) held for 5 cycles
    b4.o_r = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_i_r",  32'(b4.i_r), 32'd0);
      chk("bp_re",   32'(b4.sram_re), 32'd0);
      chk("bp_o_v",  32'(b4.o_v), 32'd1);
      chk("bp_o_id", 32'(b4.o_id), 32'd0);
      chk("bp_o_d",  32'(b4.o_d), mdat(8'h40));
      tick();
    end
    b4.o_r = 1'b1;
    #1;
    chk("resume_i_r", 32'(b4.i_r), 32'(oh4(1)));
    chk("resume_ra",  32'(b4.sram_ra), 32'h41);
    tick();
    chk("resume_o_id", 32'(b4.o_id), 32'd1);
    chk("resume_o_d",  32'(b4.o_d), mdat(8'h41));

    // Address change while requester 2 waits behind a stall
    b4.i_v = oh4(2);
    b4.o_r = 1'b0;
    b4.i_a[16 +: 8] = 8'h55;
    #1;
    chk("wait_i_r", 32'(b4.i_r), 32'd0);
    tick();
    b4.i_a[16 +: 8] = 8'h77;
    b4.o_r = 1'b1;
    #1;
    chk("achg_i_r", 32'(b4.i_r), 32'(oh4(2)));
    chk("achg_ra",  32'(b4.sram_ra), 32'h77);
    tick();
    b4.i_v = '0;
    b4.o_r = 1'b0;
    #1;
    chk("achg_o_id", 32'(b4.o_id), 32'd2);
    chk("achg_o_d",  32'(b4.o_d), mdat(8'h77));

    // Reset mid-stream: stalled response dropped, pointer (3) back to 0
    tick();
    chk("rm_pre_o_v", 32'(b4.o_v), 32'd1);
    reset = 1'b0;
    tick();
    chk("rm_o_v",  32'(b4.o_v), 32'd0);
    chk("rm_o_id", 32'(b4.o_id), 32'd0);
    reset = 1'b1;
    b4.i_v = '1;
    b4.o_r = 1'b1;
    #1;
    chk("rm_ptr_i_r", 32'(b4.i_r), 32'(oh4(0)));
    tick();
    b4.i_v = '0;
    #1;
    chk("rm_o_d", 32'(b4.o_d), mdat(8'h40));
    tick();

    // Three-way pointer wrap
    b3.o_r = 1'b1;
    b3.i_a[0 +: 8]  = 8'h30;
    b3.i_a[8 +: 8]  = 8'h31;
    b3.i_a[16 +: 8] = 8'h32;
    b3.i_v = oh3(2);
    #1;
    chk("w3_g2_i_r", 32'(b3.i_r), 32'(oh3(2)));
    chk("w3_g2_ra",  32'(b3.sram_ra), 32'h32);
    tick();
    b3.i_v = oh3(0);
    #1;
    chk("w3_g0_i_r", 32'(b3.i_r), 32'(oh3(0)));
    chk("w3_o_id2",  32'(b3.o_id), 32'd2);
    tick();
    b3.i_v = oh3(0) | oh3(2);
    #1;
    chk("w3_ptr1_i_r", 32'(b3.i_r), 32'(oh3(2)));
    chk("w3_o_id0",    32'(b3.o_id), 32'd0);
    chk("w3_o_d0",     32'(b3.o_d), mdat(8'h30));
    tick();
    b3.i_v = '1;
    #1;
    chk("w3_wrap_i_r", 32'(b3.i_r), 32'(oh3(0)));
    chk("w3_o_id2b",   32'(b3.o_id), 32'd2);
    tick();
    b3.i_v = '0;
    #1;
    chk("w3_o_id0b", 32'(b3.o_id), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
